sseg_scan_decoder: RTL

Receive-side counterpart of the game timer's multiplexed four-digit seven-segment output. Samples the scanned `sseg`/`an` bus, waits for each digit slot to settle, decodes each active-low segment pattern back to a 4-bit digit code, and presents a complete four-digit frame atomically with a one-cycle strobe. Used in board-to-board loopback and as a self-check monitor beside the timer display path.

---
 rtl/sseg_scan_decoder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: samples a multiplexed 4-digit active-low seven-segment
// bus, waits for each digit slot to settle, decodes the pattern back to a
// digit code and publishes a complete frame atomically with a strobe.
// Optional feature macro: SSEG_SCAN_TIMEOUT_EN (idle counter drives stale).
module sseg_scan_decoder #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 1048575
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  sseg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        err,
  output logic        stale
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_HOLD} state_t;

  typedef struct packed {
    logic [6:0] sseg;
    logic [3:0] an;
  } in_t;

  localparam logic [7:0] SETTLE_V = 8'(SETTLE);

  in_t         in_q;
  state_t      state, state_n;
  logic [7:0]  stab;
  logic [3:0]  mask;
  logic [15:0] shadow;
  logic        change;
  logic [3:0]  dec_code;
  logic        dec_bad;

  // True when exactly one digit enable is driven low.
  function automatic logic onehot_low(input logic [3:0] a);
    case (a)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  assign change = ({sseg, an} != in_q);

  // Segment pattern {g..a} active-low to digit code; unknown patterns flag bad.
  always_comb begin
    dec_bad  = 1'b0;
    dec_code = 4'hE;
    case (in_q.sseg)
      7'b1000000: dec_code = 4'h0;
      7'b1111001: dec_code = 4'h1;
      7'b0100100: dec_code = 4'h2;
      7'b0110000: dec_code = 4'h3;
      7'b0011001: dec_code = 4'h4;
      7'b0010010: dec_code = 4'h5;
      7'b0000010: dec_code = 4'h6;
      7'b1111000: dec_code = 4'h7;
      7'b0000000: dec_code = 4'h8;
      7'b0010000: dec_code = 4'h9;
      7'b1111111: dec_code = 4'hF;
      default:    dec_bad  = 1'b1;
    endcase
  end

  // Input register and saturating stability counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_q <= '{sseg: 7'h7F, an: 4'hF};
      stab <= 8'd0;
    end else begin
      in_q <= '{sseg: sseg, an: an};
      if (change)
        stab <= 8'd0;
      else if (stab != SETTLE_V)
        stab <= stab + 8'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state logic. A change arriving while in CAPT is followed directly so
  // the next slot is not lost; a change on the CAPT-entry edge cancels capture
  // so only a value that stayed stable is ever decoded.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (onehot_low(in_q.an)) state_n = S_WAIT;
      S_WAIT: begin
        if (!onehot_low(in_q.an))             state_n = S_IDLE;
        else if (stab == SETTLE_V && !change) state_n = S_CAPT;
      end
      S_CAPT: begin
        if (change) state_n = onehot_low(an) ? S_WAIT : S_IDLE;
        else        state_n = S_HOLD;
      end
      S_HOLD: if (change) state_n = onehot_low(an) ? S_WAIT : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Shadow slot write on capture; the active slot is the low enable bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow <= 16'h0000;
    end else if (state == S_CAPT) begin
      for (int i = 0; i < 4; i++)
        if (!in_q.an[i]) shadow[i*4 +: 4] <= dec_code;
    end
  end

  // Frame assembly: mask tracks captured slots, full mask publishes the frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask        <= 4'h0;
      digits      <= 16'h0000;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (mask == 4'hF) begin
        digits      <= shadow;
        frame_valid <= 1'b1;
        mask        <= 4'h0;
      end else if (state == S_CAPT) begin
        mask <= mask | ~in_q.an;
      end
      if (state == S_CAPT && dec_bad)
        err <= 1'b1;
    end
  end

`ifdef SSEG_SCAN_TIMEOUT_EN
  logic [23:0] idle_cnt;

  // Idle counter since last capture; stale follows it one edge later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= 24'd0;
      stale    <= 1'b0;
    end else begin
      if (state == S_CAPT)
        idle_cnt <= 24'd0;
      else if (idle_cnt != 24'hFFFFFF)
        idle_cnt <= idle_cnt + 24'd1;
      stale <= (idle_cnt >= 24'(TIMEOUT));
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |24'(TIMEOUT);
  assign stale = 1'b0;
`endif

endmodule
